// File: rtl/arm_pkg.sv
// Shared ARM core definitions: register addressing, datapath width and NZCV bit positions.
package arm_pkg;

  localparam int DATA_W = 32;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t REG_PC = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for R0-R14; R15 (PC) is never tracked.
module reg_scoreboard
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en_i,
  input  reg_addr_t   set_addr_i,
  input  logic        clr_en_i,
  input  reg_addr_t   clr_addr_i,
  output logic [15:0] mask_o
);

  logic [14:0] pend_q;
  logic [14:0] pend_d;

  // Set is applied after clear so a same-cycle reissue keeps ownership of the register.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < 15; i++) begin
      if (clr_en_i && (clr_addr_i == reg_addr_t'(i))) pend_d[i] = 1'b0;
      if (set_en_i && (set_addr_i == reg_addr_t'(i))) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign mask_o = {1'b0, pend_q};

endmodule

// File: rtl/reg_file_wb.sv
// ARM register file at the writeback end: R0-R14 storage, R15 reads from the PC,
// write-through bypass to three read ports, NZCV flags and the pending scoreboard.
module reg_file_wb
  import arm_pkg::*;
#(
  parameter int DATA_W = arm_pkg::DATA_W,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_enable_in,
  input  reg_addr_t         wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flags_write_enable_in,
  input  logic [3:0]        flags_in,
  input  logic              issue_enable,
  input  reg_addr_t         issue_addr,
  input  reg_addr_t         rn_addr,
  input  reg_addr_t         rm_addr,
  input  reg_addr_t         rs_addr,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [3:0]        flags_out,
  output logic              rn_pending,
  output logic              rm_pending,
  output logic              rs_pending,
  output logic [15:0]       pending_mask
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [3:0]        flags_q;

  logic wr_en;
  logic issue_en;
  logic flags_en;

  // Commands are masked while reset is low so outputs reflect only the reset state.
  assign wr_en    = reg_write_enable_in & reset & (wb_addr != REG_PC);
  assign issue_en = issue_enable & reset;
  assign flags_en = flags_write_enable_in & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (flags_en) begin
      flags_q <= flags_in;
    end
  end

  assign rn_data = (rn_addr == REG_PC) ? pc_in :
                   (wr_en && (wb_addr == rn_addr)) ? wb_data : regs_q[rn_addr];
  assign rm_data = (rm_addr == REG_PC) ? pc_in :
                   (wr_en && (wb_addr == rm_addr)) ? wb_data : regs_q[rm_addr];
  assign rs_data = (rs_addr == REG_PC) ? pc_in :
                   (wr_en && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];

  assign flags_out = flags_en ? flags_in : flags_q;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (reset),
    .set_en_i   (issue_en),
    .set_addr_i (issue_addr),
    .clr_en_i   (wr_en),
    .clr_addr_i (wb_addr),
    .mask_o     (pending_mask)
  );

  // A writeback landing this cycle satisfies the operand through the bypass.
  assign rn_pending = pending_mask[rn_addr] & ~(wr_en && (wb_addr == rn_addr));
  assign rm_pending = pending_mask[rm_addr] & ~(wr_en && (wb_addr == rm_addr));
  assign rs_pending = pending_mask[rs_addr] & ~(wr_en && (wb_addr == rs_addr));

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: reset, bypass, R15, scoreboard and flags behaviour.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic        reg_write_enable_in;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flags_write_enable_in;
  logic [3:0]  flags_in;
  logic        issue_enable;
  logic [3:0]  issue_addr;
  logic [3:0]  rn_addr, rm_addr, rs_addr;
  logic [31:0] pc_in;
  logic [31:0] rn_data, rm_data, rs_data;
  logic [3:0]  flags_out;
  logic        rn_pending, rm_pending, rs_pending;
  logic [15:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_wb dut (
    .clk                   (clk),
    .reset                 (reset),
    .reg_write_enable_in   (reg_write_enable_in),
    .wb_addr               (wb_addr),
    .wb_data               (wb_data),
    .flags_write_enable_in (flags_write_enable_in),
    .flags_in              (flags_in),
    .issue_enable          (issue_enable),
    .issue_addr            (issue_addr),
    .rn_addr               (rn_addr),
    .rm_addr               (rm_addr),
    .rs_addr               (rs_addr),
    .pc_in                 (pc_in),
    .rn_data               (rn_data),
    .rm_data               (rm_data),
    .rs_data               (rs_data),
    .flags_out             (flags_out),
    .rn_pending            (rn_pending),
    .rm_pending            (rm_pending),
    .rs_pending            (rs_pending),
    .pending_mask          (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_enable_in   = 1'b0;
    flags_write_enable_in = 1'b0;
    issue_enable          = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    wb_addr = 4'd0; wb_data = '0; flags_in = 4'b0; issue_addr = 4'd0;
    rn_addr = 4'd0; rm_addr = 4'd0; rs_addr = 4'd0; pc_in = 32'h0000_0108;
    step(); step();
    reset = 1'b1;

    // Populate state that reset must clear.
    step();
    reg_write_enable_in = 1'b1; wb_addr = 4'd3; wb_data = 32'hA5A5_A5A5;
    issue_enable = 1'b1; issue_addr = 4'd9;
    flags_write_enable_in = 1'b1; flags_in = 4'b1111;
    step();
    idle();
    rn_addr = 4'd3; rm_addr = 4'd3; rs_addr = 4'd9;
    #1;
    chk("pre_rst_r3", rn_data, 32'hA5A5_A5A5);
    chk("pre_rst_mask", {16'h0, pending_mask}, 32'h0000_0200);
    chk("pre_rst_flags", {28'h0, flags_out}, 32'hF);

    // Asynchronous reset mid-cycle, with a write presented that must be ignored.
    #1;
    reset = 1'b0;
    reg_write_enable_in = 1'b1; wb_addr = 4'd3; wb_data = 32'hFFFF_FFFF;
    issue_enable = 1'b1; issue_addr = 4'd4;
    #1;
    chk("rst_rn", rn_data, 32'h0);
    chk("rst_rm", rm_data, 32'h0);
    chk("rst_rs_pend", {31'h0, rs_pending}, 32'h0);
    chk("rst_mask", {16'h0, pending_mask}, 32'h0);
    chk("rst_flags", {28'h0, flags_out}, 32'h0);
    step();
    chk("rst_edge_rn", rn_data, 32'h0);
    chk("rst_edge_mask", {16'h0, pending_mask}, 32'h0);
    idle();
    reset = 1'b1;
    #1;
    chk("post_rst_rn", rn_data, 32'h0);
    chk("post_rst_mask", {16'h0, pending_mask}, 32'h0);

    // Write-through bypass and subsequent stored value.
    step();
    reg_write_enable_in = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEAD_BEEF;
    rn_addr = 4'd5; rm_addr = 4'd3; rs_addr = 4'd6;
    #1;
    chk("byp_rn", rn_data, 32'hDEAD_BEEF);
    chk("byp_rm_other", rm_data, 32'h0);
    step();
    idle();
    rm_addr = 4'd5; rs_addr = 4'd5;
    #1;
    chk("stored_rn", rn_data, 32'hDEAD_BEEF);
    chk("stored_rs", rs_data, 32'hDEAD_BEEF);

    // R15: writes dropped, reads return pc_in.
    step();
    reg_write_enable_in = 1'b1; wb_addr = 4'd15; wb_data = 32'h0000_1234;
    pc_in = 32'h0000_0108; rm_addr = 4'd15;
    #1;
    chk("r15_wr_rd", rm_data, 32'h0000_0108);
    step();
    idle();
    pc_in = 32'h0000_0200;
    rn_addr = 4'd5; rs_addr = 4'd3;
    #1;
    chk("r15_rd_after", rm_data, 32'h0000_0200);
    chk("r15_r5_kept", rn_data, 32'hDEAD_BEEF);
    chk("r15_r3_kept", rs_data, 32'h0);
    chk("r15_mask", {16'h0, pending_mask}, 32'h0);

    // Scoreboard: issue R7 in cycle 0, writeback in cycle 3.
    step();
    issue_enable = 1'b1; issue_addr = 4'd7; rs_addr = 4'd7;
    #1;
    chk("sb_c0_pend", {31'h0, rs_pending}, 32'h0);
    step();
    idle();
    #1;
    chk("sb_c1_pend", {31'h0, rs_pending}, 32'h1);
    chk("sb_c1_mask", {16'h0, pending_mask}, 32'h0000_0080);
    step();
    #1;
    chk("sb_c2_pend", {31'h0, rs_pending}, 32'h1);
    step();
    reg_write_enable_in = 1'b1; wb_addr = 4'd7; wb_data = 32'h0000_0077;
    #1;
    chk("sb_c3_pend", {31'h0, rs_pending}, 32'h0);
    chk("sb_c3_data", rs_data, 32'h0000_0077);
    chk("sb_c3_mask", {16'h0, pending_mask}, 32'h0000_0080);
    step();
    idle();
    #1;
    chk("sb_c4_mask", {16'h0, pending_mask}, 32'h0);
    chk("sb_c4_data", rs_data, 32'h0000_0077);

    // Same-cycle set and clear on R2: set wins, data stored.
    step();
    issue_enable = 1'b1; issue_addr = 4'd2; rn_addr = 4'd2;
    step();
    issue_enable = 1'b1; issue_addr = 4'd2;
    reg_write_enable_in = 1'b1; wb_addr = 4'd2; wb_data = 32'h0000_0055;
    #1;
    chk("col_pre_mask", {16'h0, pending_mask}, 32'h0000_0004);
    chk("col_rn_pend", {31'h0, rn_pending}, 32'h0);
    chk("col_rn_data", rn_data, 32'h0000_0055);
    step();
    idle();
    issue_enable = 1'b1; issue_addr = 4'd15; rm_addr = 4'd15;
    #1;
    chk("col_mask", {16'h0, pending_mask}, 32'h0000_0004);
    chk("col_rn_stored", rn_data, 32'h0000_0055);
    chk("col_rn_pend_after", {31'h0, rn_pending}, 32'h1);
    step();
    idle();
    // Clearing an already-clear bit is harmless.
    reg_write_enable_in = 1'b1; wb_addr = 4'd9; wb_data = 32'h0000_0009;
    #1;
    chk("r15_issue_mask", {16'h0, pending_mask}, 32'h0000_0004);
    chk("r15_issue_pend", {31'h0, rm_pending}, 32'h0);
    step();
    idle();
    #1;
    chk("clr_clear_mask", {16'h0, pending_mask}, 32'h0000_0004);

    // Flags bypass, hold, then asynchronous reset without a clock edge.
    step();
    flags_write_enable_in = 1'b1; flags_in = 4'b1010;
    #1;
    chk("flg_byp", {28'h0, flags_out}, 32'hA);
    step();
    idle();
    flags_in = 4'b0101;
    #1;
    chk("flg_hold", {28'h0, flags_out}, 32'hA);
    #1;
    reset = 1'b0;
    #1;
    chk("flg_async_rst", {28'h0, flags_out}, 32'h0);
    chk("async_rst_rn", rn_data, 32'h0);
    chk("async_rst_mask", {16'h0, pending_mask}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Sixteen-entry, 32-bit ARM general-purpose register file that terminates the writeback end of the pipeline: it accepts the register-write command from the MEM/WB stage and serves the decode stage's operand reads. It holds the NZCV status flags, bypasses same-cycle writes to readers, and keeps a per-register pending scoreboard that the hazard unit uses to stall decode.

## Interface
- DATA_W, 32, register and data width
- NREG, 16, number of registers, fixed at 16 (R0–R15)
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- reg_write_enable_in  in  1  WB write command, valid this cycle
- wb_addr  in  4  WB destination register
- wb_data  in  DATA_W  WB write data (already muxed by mem_to_reg select)
- flags_write_enable_in  in  1  update NZCV this cycle
- flags_in  in  4  NZCV value to write, {N,Z,C,V}
- issue_enable  in  1  decode issues an instruction that writes issue_addr
- issue_addr  in  4  destination being issued
- rn_addr, rm_addr, rs_addr  in  4 each  read addresses
- pc_in  in  DATA_W  value returned for R15 reads (PC+8 from fetch)
- rn_data, rm_data, rs_data  out  DATA_W each  read data
- flags_out  out  4  current NZCV (bypassed)
- rn_pending, rm_pending, rs_pending  out  1 each  source has an outstanding write
- pending_mask  out  16  full scoreboard, bit i = Ri pending

## Operation
- Storage: R0–R14 in flops; R15 is not stored. Writes with wb_addr = 15 are dropped; reads of 15 return pc_in.
- Write: on rising clk, if reg_write_enable_in and wb_addr != 15, R[wb_addr] <= wb_data.
- Read: combinational. If the read address equals wb_addr, reg_write_enable_in = 1 and the address is not 15, return wb_data (write-through bypass). Otherwise return the stored value. All three ports are independent; identical addresses on multiple ports are legal.
- Flags: on clk, if flags_write_enable_in, NZCV <= flags_in. flags_out bypasses flags_in when flags_write_enable_in = 1.
- Scoreboard, per bit i in 0..14:
  - Set when issue_enable and issue_addr = i.
  - Cleared when reg_write_enable_in and wb_addr = i.
  - Set and clear on the same bit in the same cycle: set wins, because the newly issued instruction owns the register.
  - Bit 15 is never set and reads 0.
- x_pending = pending_mask[x_addr] & ~(same-cycle clear of that bit). A bypassed operand is therefore not reported as pending.
- Clearing a bit that is already clear, or setting one that is already set, is harmless and causes no error.

## Timing
- Reset (reset = 0, asynchronous): R0–R14 = 0, NZCV = 4'b0000, pending_mask = 0. All outputs are driven from these values while in reset. Writes and issues presented during reset are ignored.
- Reset deassertion is synchronised externally. The first edge after release performs normal updates.
- Write-to-read latency is 0 cycles via bypass. The stored value is visible from the cycle after the edge.
- Scoreboard set is visible on pending outputs from the cycle after issue. A clear is visible in the same cycle through the qualification term, and in mask state from the next cycle.
- No handshake or backpressure: every asserted enable is consumed on the edge where it is presented.

## Structure
- Shared package arm_pkg: REG_PC = 4'd15, DATA_W, NZCV bit indices (N = 3, Z = 2, C = 1, V = 0), reg_addr_t (4-bit) typedef.
- One sub-module, reg_scoreboard, holds the 15 pending bits and the set/clear priority logic. The data array, bypass muxes and flags stay in reg_file_wb.

## Test plan
- Reset then reads: assert reset with R3 previously written -> all rn/rm/rs data = 0, flags_out = 0, pending_mask = 0 while reset = 0 and after release.
- Write/bypass: we = 1, wb_addr = 5, wb_data = 0xDEADBEEF, rn_addr = 5 in the same cycle -> rn_data = 0xDEADBEEF that cycle and on every later cycle.
- R15 handling: write wb_addr = 15, data 0x1234, pc_in = 0x00000108, rm_addr = 15 -> rm_data = 0x108. A subsequent read of R15 is still pc_in. No other register changes.
- Scoreboard: issue R7 at cycle 0 -> rs_pending (rs_addr = 7) = 1 from cycle 1. WB write to R7 at cycle 3 -> rs_pending = 0 in cycle 3 and rs_data = wb_data.
- Set/clear collision: R2 pending; in one cycle, issue R2 and WB write R2 = 0x55 -> pending_mask[2] = 1 next cycle and R2 stored = 0x55.
- Flags: flags_write_enable_in = 1, flags_in = 4'b1010 -> flags_out = 1010 same cycle and held. Mid-operation reset with reset = 0 -> flags_out = 0 immediately, with no clock edge.
